ps2_tx: RTL

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx_if.sv | 13 +
 rtl/ps2_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ps2_tx_if.sv
// Host-side handshake for the PS/2 command transmitter: request/byte in,
// frame status out.
interface ps2_tx_if;
  logic       wr;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (output wr, din, input busy, done, ack_err, timeout);
  modport slave  (input wr, din, output busy, done, ack_err, timeout);
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, sends a start bit,
// eight data bits LSB first, odd parity and stop, then samples the device ACK.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_tx_if.slave  host,
  input  logic     ps2_clk_in,
  input  logic     ps2_data_in,
  output logic     ps2_clk_oe,
  output logic     ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST   = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, RELEASE
  } state_t;

  state_t        state_reg, state_next;
  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic          fe;
  logic [IW-1:0] inh_cnt_reg;
  logic [TW-1:0] frame_cnt_reg;
  logic [3:0]    bit_idx_reg;
  logic [9:0]    frame_reg;
  logic          ack_err_reg;
  logic          accept;
  logic          abort;
  logic          in_frame;

  // Synchronizers idle high, matching a released open-drain bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  assign fe       = clk_s3 & ~clk_s2;
  assign in_frame = (state_reg == START) || (state_reg == SHIFT) ||
                    (state_reg == ACK)   || (state_reg == RELEASE);
  assign abort    = in_frame && (frame_cnt_reg == FRAME_LAST);

  always_comb begin
    state_next  = state_reg;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    host.busy   = (state_reg != IDLE);
    host.done   = 1'b0;
    host.timeout = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.wr) begin
          accept     = 1'b1;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt_reg == INH_LAST) begin
          ps2_data_oe = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        ps2_data_oe = 1'b1;
        if (fe) state_next = SHIFT;
      end
      SHIFT: begin
        // frame_reg holds {stop, parity, data}; the line is driven low for a 0 bit.
        ps2_data_oe = (bit_idx_reg <= 4'd9) ? ~frame_reg[bit_idx_reg] : 1'b0;
        if (fe && bit_idx_reg == 4'd8) state_next = ACK;
      end
      ACK: begin
        if (fe) state_next = RELEASE;
      end
      RELEASE: begin
        if (clk_s2 && data_s2) begin
          host.done  = 1'b1;
          host.busy  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // An expired frame overrides everything: release the bus and report.
    if (abort) begin
      ps2_clk_oe   = 1'b0;
      ps2_data_oe  = 1'b0;
      host.done    = 1'b0;
      host.busy    = 1'b0;
      host.timeout = 1'b1;
      state_next   = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      inh_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      bit_idx_reg   <= 4'd0;
      frame_reg     <= 10'h3FF;
      ack_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == INHIBIT) inh_cnt_reg <= inh_cnt_reg + 1'b1;
      else                      inh_cnt_reg <= '0;

      if (in_frame) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      else          frame_cnt_reg <= '0;

      if (accept) begin
        frame_reg   <= {1'b1, ~^host.din, host.din};
        bit_idx_reg <= 4'd0;
        ack_err_reg <= 1'b0;
      end else if (fe && (state_reg == SHIFT || state_reg == ACK) &&
                   bit_idx_reg != 4'hF) begin
        bit_idx_reg <= bit_idx_reg + 4'd1;
      end

      if (abort)                           ack_err_reg <= 1'b1;
      else if (state_reg == ACK && fe)     ack_err_reg <= data_s2;
    end
  end

  assign host.ack_err = ack_err_reg;
endmodule
